// File: rtl/tpu_result_drain_pkg.sv
// Shared sizing, FSM encoding and payload types for the result drain path.
package tpu_result_drain_pkg;

  localparam int unsigned ARRAY_SIZE        = 32;
  localparam int unsigned OUTPUT_DATA_WIDTH = 32;
  localparam int unsigned DATA_WIDTH        = 16;
  localparam int unsigned SRAM_DATA_WIDTH   = 64;
  localparam int unsigned FIFO_DEPTH        = 2;
  localparam int unsigned ADDR_WIDTH        = 10;

  localparam int unsigned LPW           = SRAM_DATA_WIDTH / DATA_WIDTH;
  localparam int unsigned BEATS_PER_ROW = ARRAY_SIZE / LPW;

  localparam int unsigned SHIFT_W    = 5;
  localparam int unsigned NROWS_W    = 7;
  localparam int unsigned ROW_ADDR_W = 6;
  localparam int unsigned ROW_W      = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int unsigned LANE_W     = $clog2(LPW);
  localparam int unsigned BEAT_W     = $clog2(BEATS_PER_ROW);
  localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);

  // One extra bit so the rounding add can never wrap.
  localparam int unsigned WIDE_W = OUTPUT_DATA_WIDTH + 1;

  localparam logic signed [WIDE_W-1:0] SAT_MAX = WIDE_W'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [WIDE_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ROW_ADDR_W-1:0]                        addr;
    logic [ARRAY_SIZE-1:0][OUTPUT_DATA_WIDTH-1:0] lanes;
  } row_entry_t;

  typedef logic [LPW-1:0][DATA_WIDTH-1:0] beat_word_t;

  // Each result row owns BEATS_PER_ROW consecutive output words.
  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ROW_ADDR_W-1:0] row,
                                                      input logic [BEAT_W-1:0]     beat);
    return ADDR_WIDTH'({row, beat});
  endfunction

endpackage

// File: rtl/tpu_requant_lane.sv
// One accumulator lane: round-half-up arithmetic right shift, then clamp to
// the signed DATA_WIDTH range, flagging any clamp.
module tpu_requant_lane
  import tpu_result_drain_pkg::*;
(
  input  logic [OUTPUT_DATA_WIDTH-1:0] x,
  input  logic [SHIFT_W-1:0]           shift,
  output logic [DATA_WIDTH-1:0]        y_c,
  output logic                         sat_c
);

  logic signed [WIDE_W-1:0] wide;
  logic signed [WIDE_W-1:0] rnd;
  logic signed [WIDE_W-1:0] t;

  always_comb begin
    wide  = {x[OUTPUT_DATA_WIDTH-1], x};
    rnd   = '0;
    t     = '0;
    y_c   = '0;
    sat_c = 1'b0;
    if (shift != '0) begin
      rnd = WIDE_W'(1) << (shift - SHIFT_W'(1));
    end
    t = (wide + rnd) >>> shift;
    if (t > SAT_MAX) begin
      y_c   = SAT_MAX[DATA_WIDTH-1:0];
      sat_c = 1'b1;
    end else if (t < SAT_MIN) begin
      y_c   = SAT_MIN[DATA_WIDTH-1:0];
      sat_c = 1'b1;
    end else begin
      y_c = t[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/tpu_result_drain.sv
// Drains systolic result rows: buffers them in a small FIFO, requantizes one
// beat of lanes per cycle and writes packed words into the next layer's SRAM.
module tpu_result_drain
  import tpu_result_drain_pkg::*;
(
  input  logic                       clk,
  input  logic                       srstn,
  input  logic                       start,
  input  logic [SHIFT_W-1:0]         shift,
  input  logic [NROWS_W-1:0]         num_rows,
  input  logic                       row_valid,
  output logic                       row_ready,
  input  logic [ROW_W-1:0]           row_data,
  input  logic [ROW_ADDR_W-1:0]      row_addr,
  output logic                       out_we,
  output logic [ADDR_WIDTH-1:0]      out_waddr,
  output logic [SRAM_DATA_WIDTH-1:0] out_wdata,
  output logic                       sat_flag,
  output logic                       busy,
  output logic                       done
);

  state_t                     state_q, state_d;
  logic [SHIFT_W-1:0]         shift_q, shift_d;
  logic [NROWS_W-1:0]         num_rows_q, num_rows_d;
  logic [NROWS_W-1:0]         acc_q, acc_d;
  logic [NROWS_W-1:0]         row_cnt_q, row_cnt_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  row_entry_t                 fifo_mem [FIFO_DEPTH];
  row_entry_t                 head;
  logic                       push;
  logic                       pop;
  logic                       row_ready_d;
  logic                       out_we_d;
  logic [ADDR_WIDTH-1:0]      out_waddr_d;
  logic [SRAM_DATA_WIDTH-1:0] out_wdata_d;
  logic                       sat_flag_d;
  logic                       busy_d;
  logic                       done_d;
  beat_word_t                 beat_word;
  logic [LPW-1:0]             beat_sat;

  assign head = fifo_mem[rd_ptr_q];

  // Only the LPW lanes of the current beat are requantized each cycle.
  for (genvar k = 0; k < LPW; k++) begin : g_lane
    tpu_requant_lane u_lane (
      .x     (head.lanes[{beat_q, LANE_W'(k)}]),
      .shift (shift_q),
      .y_c   (beat_word[k]),
      .sat_c (beat_sat[k])
    );
  end

  // Next-state, FIFO bookkeeping and registered-output values.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    num_rows_d  = num_rows_q;
    acc_d       = acc_q;
    row_cnt_d   = row_cnt_q;
    beat_d      = beat_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    sat_flag_d  = sat_flag;
    out_we_d    = 1'b0;
    out_waddr_d = out_waddr;
    out_wdata_d = out_wdata;
    row_ready_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d    = shift;
          num_rows_d = num_rows;
          acc_d      = '0;
          row_cnt_d  = '0;
          beat_d     = '0;
          sat_flag_d = 1'b0;
          state_d    = (num_rows == '0) ? ST_FIN : ST_RUN;
        end
      end
      ST_RUN: begin
        push = row_valid && row_ready;
        if (push) begin
          acc_d = acc_q + NROWS_W'(1);
        end
        if (count_q != '0) begin
          out_we_d    = 1'b1;
          out_waddr_d = word_addr(head.addr, beat_q);
          out_wdata_d = beat_word;
          sat_flag_d  = sat_flag | (|beat_sat);
          beat_d      = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS_PER_ROW - 1)) begin
            pop       = 1'b1;
            row_cnt_d = row_cnt_q + NROWS_W'(1);
            if (row_cnt_d == num_rows_q) begin
              state_d = ST_FIN;
            end
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    // Ready is registered from next-cycle occupancy, so a same-cycle pop
    // never lets a full FIFO accept.
    row_ready_d = (state_d == ST_RUN) && (count_d < CNT_W'(FIFO_DEPTH)) &&
                  (acc_d < num_rows_d);
    busy_d      = (state_d == ST_RUN);
    done_d      = (state_q == ST_FIN);
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      num_rows_q <= '0;
      acc_q      <= '0;
      row_cnt_q  <= '0;
      beat_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      row_ready  <= 1'b0;
      out_we     <= 1'b0;
      out_waddr  <= '0;
      out_wdata  <= '0;
      sat_flag   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      num_rows_q <= num_rows_d;
      acc_q      <= acc_d;
      row_cnt_q  <= row_cnt_d;
      beat_q     <= beat_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      row_ready  <= row_ready_d;
      out_we     <= out_we_d;
      out_waddr  <= out_waddr_d;
      out_wdata  <= out_wdata_d;
      sat_flag   <= sat_flag_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

  // Row storage for the FIFO.
  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      fifo_mem <= '{default: '0};
    end else if (push) begin
      fifo_mem[wr_ptr_q] <= '{addr: row_addr, lanes: row_data};
    end
  end

endmodule

// File: tb/tb_tpu_result_drain.sv
// Randomized bench for tpu_result_drain against a behavioural requantize/pack model.
`timescale 1ns/1ps
module tb_tpu_result_drain;

  logic          clk = 1'b0;
  logic          srstn;
  logic          start;
  logic [4:0]    shift;
  logic [6:0]    num_rows;
  logic          row_valid;
  logic          row_ready;
  logic [1023:0] row_data;
  logic [5:0]    row_addr;
  logic          out_we;
  logic [9:0]    out_waddr;
  logic [63:0]   out_wdata;
  logic          sat_flag;
  logic          busy;
  logic          done;

  tpu_result_drain dut (
    .clk       (clk),
    .srstn     (srstn),
    .start     (start),
    .shift     (shift),
    .num_rows  (num_rows),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_addr  (row_addr),
    .out_we    (out_we),
    .out_waddr (out_waddr),
    .out_wdata (out_wdata),
    .sat_flag  (sat_flag),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          done0 = 0;
  int          start_edge = 0;
  int          sh_m = 0;
  bit          sat_m = 1'b0;
  logic [73:0] got_q [$];
  logic [73:0] exp_q [$];
  int          wr_cyc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (out_we) begin
      got_q.push_back({out_waddr, out_wdata});
      wr_cyc_q.push_back(cyc);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rq(input logic [31:0] x, input int sh, inout bit s);
    longint v;
    v = longint'($signed(x));
    if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
    if (v > 32767) begin
      v = 32767;
      s = 1'b1;
    end else if (v < -32768) begin
      v = -32768;
      s = 1'b1;
    end
    return v[15:0];
  endfunction

  task automatic expect_row(input logic [5:0] a, input logic [1023:0] d);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) begin
      for (int k = 0; k < 4; k++) w[16*k +: 16] = rq(d[32*(4*b+k) +: 32], sh_m, sat_m);
      exp_q.push_back({10'(a * 8 + b), w});
    end
  endtask

  function automatic logic [31:0] rand_lane();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 2000)) - 32'd1000;
      1:       return $urandom();
      2:       return 32'($urandom_range(0, 32'h001F_FFFF)) - 32'h0010_0000;
      default: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    endcase
  endfunction

  function automatic logic [1023:0] rand_row();
    logic [1023:0] d;
    for (int i = 0; i < 32; i++) d[32*i +: 32] = rand_lane();
    return d;
  endfunction

  task automatic start_job(input int sh, input int nr);
    shift    = 5'(sh);
    num_rows = 7'(nr);
    start    = 1'b1;
    sh_m     = sh;
    sat_m    = 1'b0;
    done0    = done_cnt;
    @(negedge clk);
    start      = 1'b0;
    start_edge = cyc;
  endtask

  // Called at a negedge; acc_edge is the clock edge that took the row.
  task automatic send_row(input logic [5:0] a, input logic [1023:0] d, input int budget,
                          output bit ok, output int acc_edge);
    int n = 0;
    row_valid = 1'b1;
    row_addr  = a;
    row_data  = d;
    while (!row_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok       = row_ready;
    acc_edge = cyc + 1;
    if (ok) expect_row(a, d);
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == done0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt - done0, 1);
    check({tag, "_busy_after"}, busy, 0);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check({tag, "_wr"}, got_q[i], exp_q[i]);
    check({tag, "_sat"}, sat_flag, sat_m);
    got_q.delete();
    exp_q.delete();
    wr_cyc_q.delete();
  endtask

  initial begin
    logic [1023:0] d;
    logic [73:0]   w0;
    bit            ok;
    int            e [4];
    int            nr;
    bit            found;

    srstn     = 1'b0;
    start     = 1'b0;
    shift     = '0;
    num_rows  = '0;
    row_valid = 1'b0;
    row_data  = '0;
    row_addr  = '0;
    repeat (3) @(negedge clk);
    check("rst_row_ready", row_ready, 0);
    check("rst_out_we", out_we, 0);
    check("rst_out_waddr", out_waddr, 0);
    check("rst_out_wdata", out_wdata, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    srstn = 1'b1;
    @(negedge clk);

    // Basic drain: lane i = i at row 3, no shift.
    start_job(0, 1);
    check("basic_busy", busy, 1);
    for (int i = 0; i < 32; i++) d[32*i +: 32] = 32'(i);
    send_row(6'd3, d, 50, ok, e[0]);
    check("basic_accept", ok, 1);
    wait_done("basic");
    w0 = (got_q.size() != 0) ? got_q[0] : '0;
    check("basic_word24", w0, {10'd24, 64'h0003_0002_0001_0000});
    check("basic_latency", (wr_cyc_q.size() != 0) ? wr_cyc_q[0] : -1, e[0] + 1);
    check("basic_done_after_last", done_cyc - ((wr_cyc_q.size() != 0) ? wr_cyc_q[$] : 0), 1);
    compare_writes("basic");

    // Rounding, round-half-up at shift 4.
    start_job(4, 1);
    d = rand_row();
    d[31:0]   = 32'd23;
    d[63:32]  = 32'd24;
    d[95:64]  = -32'sd24;
    d[127:96] = -32'sd25;
    send_row(6'($urandom_range(0, 63)), d, 50, ok, e[0]);
    check("round_accept", ok, 1);
    wait_done("round");
    w0 = (got_q.size() != 0) ? got_q[0] : '0;
    check("round_word0", w0[63:0], 64'hFFFE_FFFF_0002_0001);
    compare_writes("round");

    // Saturation, sticky through done.
    start_job(0, 1);
    d = rand_row();
    d[31:0]  = 32'h0001_0000;
    d[63:32] = 32'hFFFE_0000;
    send_row(6'd7, d, 50, ok, e[0]);
    check("sat_accept", ok, 1);
    wait_done("sat");
    w0 = (got_q.size() != 0) ? got_q[0] : '0;
    check("sat_word0_lo", w0[31:0], 32'h8000_7FFF);
    check("sat_held", sat_flag, 1);
    compare_writes("sat");

    // Zero-row job; its start also clears the sticky flag.
    start_job(0, 0);
    check("zero_sat_cleared", sat_flag, 0);
    check("zero_busy", busy, 0);
    @(negedge clk);
    check("zero_done_edge", done, 1);
    check("zero_done_delay", cyc - start_edge, 1);
    check("zero_no_we", out_we, 0);
    wait_done("zero");
    compare_writes("zero");

    // Second start while busy is ignored; extra rows are refused.
    start_job($urandom_range(0, 31), 2);
    send_row(6'($urandom_range(0, 63)), rand_row(), 50, ok, e[0]);
    check("ign_accept0", ok, 1);
    shift    = 5'($urandom_range(0, 31));
    num_rows = 7'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_row(6'($urandom_range(0, 63)), rand_row(), 50, ok, e[1]);
    check("ign_accept1", ok, 1);
    send_row(6'd9, rand_row(), 30, ok, e[2]);
    check("ign_extra_row_refused", ok, 0);
    wait_done("ign");
    compare_writes("ign");

    // Backpressure with row_valid held: FIFO of two rows, eight beats per row.
    start_job($urandom_range(0, 31), 4);
    for (int r = 0; r < 4; r++) begin
      send_row(6'(r), rand_row(), 100, ok, e[r]);
      check("bp_accept", ok, 1);
    end
    check("bp_accept_gap1", e[1] - e[0], 1);
    check("bp_accept_gap2", e[2] - e[0], 9);
    check("bp_accept_gap3", e[3] - e[0], 17);
    wait_done("bp");
    check("bp_nwr_cycles", wr_cyc_q.size(), 32);
    check("bp_first_wr", (wr_cyc_q.size() != 0) ? wr_cyc_q[0] : -1, e[0] + 1);
    check("bp_contiguous", (wr_cyc_q.size() != 0) ? wr_cyc_q[$] - wr_cyc_q[0] : -1, 31);
    compare_writes("bp");

    // Reset during beat 3 of row 0.
    start_job($urandom_range(0, 31), 2);
    send_row(6'd5, rand_row(), 50, ok, e[0]);
    check("mid_accept", ok, 1);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (out_we && out_waddr == 10'd43) found = 1'b1;
    end
    check("mid_beat3_seen", found, 1);
    srstn = 1'b0;
    #1;
    check("mid_rst_out_we", out_we, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_ready", row_ready, 0);
    @(negedge clk);
    @(negedge clk);
    srstn = 1'b1;
    @(negedge clk);
    check("mid_idle_busy", busy, 0);
    check("mid_idle_we", out_we, 0);
    got_q.delete();
    exp_q.delete();
    wr_cyc_q.delete();
    start_job($urandom_range(0, 31), 2);
    send_row(6'd63, rand_row(), 50, ok, e[0]);
    check("post_accept0", ok, 1);
    send_row(6'd0, rand_row(), 50, ok, e[1]);
    check("post_accept1", ok, 1);
    wait_done("post");
    compare_writes("post");

    // Random jobs with idle gaps between rows.
    for (int j = 0; j < 6; j++) begin
      nr = $urandom_range(1, 4);
      start_job($urandom_range(0, 31), nr);
      for (int r = 0; r < nr; r++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        send_row(6'($urandom_range(0, 63)), rand_row(), 100, ok, e[0]);
        check("rnd_accept", ok, 1);
      end
      wait_done("rnd");
      compare_writes("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
